slice_serial_demux_adder: RTL and testbench

//  Multi-cycle adder that takes both operands over one shared input bus through a 1:2 demux (sel 0 -> A, 1 -> B).

---
 rtl/adder_pkg.sv | 25 ++
 rtl/adder_slice.sv | 27 ++
 rtl/slice_serial_demux_adder.sv | 151 +++++++++++++++
 tb/tb_slice_serial_demux_adder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the slice-serial demux adder: FSM state encoding
// and the helpers that size the slice counter from WIDTH and SLICE.
// Pure declarations, no logic.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Number of SLICE-bit chunks that make up one WIDTH-bit operand
    function automatic int num_slices(input int width, input int slice);
        return width / slice;
    endfunction

    // Slice counter width; a single-slice adder still gets a 1-bit counter
    function automatic int ctr_width(input int width, input int slice);
        int n;
        n = width / slice;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple adder; also exposes the carry into its MSB.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no handshake.
module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [SLICE:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[SLICE];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/slice_serial_demux_adder.sv
// Operand pair arrives over one bus via a 1:2 demux, then is added SLICE bits per clock.
// Latency: out_valid rises NUM_SLICES enabled clocks after the capture that completes the pair.
// Backpressure: in_ready low while computing/holding a result; result held until out_ready. Define SUB_MODE_EN for subtract.
module slice_serial_demux_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    input  logic             d_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             cin,
`ifdef SUB_MODE_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NS = num_slices(WIDTH, SLICE);
    localparam int CW = ctr_width(WIDTH, SLICE);
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_param
        $error("WIDTH must be a non-zero multiple of SLICE");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             a_full;
    logic             b_full;
    logic [CW-1:0]    ctr;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             inv_b;
    logic             carry_init;

`ifdef SUB_MODE_EN
    logic sub_q;
    assign inv_b      = sub_q;
    // Subtraction is A + ~B + 1, so the incoming cin is ignored
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign inv_b      = 1'b0;
    assign carry_init = cin;
`endif

    // Current slice of each operand; B is inverted when subtracting
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_sl;
    logic             co_sl;
    logic             cmsb_sl;

    assign a_sl = a_q[int'(ctr)*SLICE +: SLICE];
    assign b_sl = b_q[int'(ctr)*SLICE +: SLICE] ^ {SLICE{inv_b}};

    adder_slice #(.SLICE(SLICE)) u_slice (
        .a     (a_sl),
        .b     (b_sl),
        .ci    (carry),
        .s     (s_sl),
        .co    (co_sl),
        .c_msb (cmsb_sl)
    );

    // Pair is complete when this capture fills the last empty operand
    logic pair_done;
    assign pair_done = (a_full | ~d_sel) & (b_full | d_sel);

    assign in_ready  = rst_n & en & ((state == IDLE) | (state == LOAD));
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Operand capture, slice-serial add and result handshake; en = 0 freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            a_full <= 1'b0;
            b_full <= 1'b0;
            ctr    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef SUB_MODE_EN
            sub_q  <= 1'b0;
`endif
        end else if (en) begin
            case (state)
                IDLE, LOAD: begin
                    if (in_valid) begin
                        if (d_sel) begin
                            b_q    <= in;
                            b_full <= 1'b1;
                        end else begin
                            a_q    <= in;
                            a_full <= 1'b1;
                        end
                        if (pair_done) begin
                            state <= CALC;
                            carry <= carry_init;
                            ctr   <= '0;
`ifdef SUB_MODE_EN
                            sub_q <= sub;
`endif
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                CALC: begin
                    sum_q[int'(ctr)*SLICE +: SLICE] <= s_sl;
                    carry <= co_sl;
                    if (ctr == LAST) begin
                        cout_q <= co_sl;
                        ovf_q  <= co_sl ^ cmsb_sl;
                        state  <= DONE;
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                DONE: begin
                    // Operands keep their values; only the full flags drop
                    if (out_ready) begin
                        state  <= IDLE;
                        a_full <= 1'b0;
                        b_full <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slice_serial_demux_adder.sv
// Self-checking bench: arithmetic reference model with per-cycle compare plus directed literal checks.
// Inputs are driven 2ns after the rising edge; outputs are compared on the falling edge.
// Covers add, carry chain, overflow, overwrite, back-pressure, enable stall, mid-op reset (and subtract if SUB_MODE_EN).
`timescale 1ns/1ps
module tb_slice_serial_demux_adder;

    localparam int W  = 16;
    localparam int S  = 4;
    localparam int NS = W / S;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         en        = 1'b0;
    logic [W-1:0] in_bus    = '0;
    logic         d_sel     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         cin       = 1'b0;
    logic         sub_op    = 1'b0;
    logic         out_ready = 1'b0;
    wire          in_ready;
    wire  [W-1:0] sum;
    wire          cout;
    wire          ovf;
    wire          out_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    slice_serial_demux_adder #(.WIDTH(W), .SLICE(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in        (in_bus),
        .d_sel     (d_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cin       (cin),
`ifdef SUB_MODE_EN
        .sub       (sub_op),
`endif
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: operand slots, a countdown of enabled cycles, and a full-width sum
    bit           m_ha, m_hb, m_busy, m_rv;
    int           m_left;
    logic [W-1:0] m_a, m_b, m_sum, m_bop;
    logic [W:0]   m_full;
    logic         m_cout, m_ovf, m_c0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ha = 0; m_hb = 0; m_busy = 0; m_rv = 0; m_left = 0;
        end else if (en) begin
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_rv   = 1;
                end
            end else if (m_rv) begin
                if (out_ready) begin
                    m_rv = 0; m_ha = 0; m_hb = 0;
                end
            end else if (in_valid) begin
                if (d_sel) begin m_b = in_bus; m_hb = 1; end
                else       begin m_a = in_bus; m_ha = 1; end
                if (m_ha && m_hb) begin
                    m_bop  = sub_op ? ~m_b : m_b;
                    m_c0   = sub_op ? 1'b1 : cin;
                    m_full = {1'b0, m_a} + {1'b0, m_bop} + {{W{1'b0}}, m_c0};
                    m_sum  = m_full[W-1:0];
                    m_cout = m_full[W];
                    m_ovf  = (m_a[W-1] == m_bop[W-1]) && (m_sum[W-1] != m_a[W-1]);
                    m_busy = 1;
                    m_left = NS;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
            chk("rst_sum",       {16'd0, sum},       32'd0);
            chk("rst_cout",      {31'd0, cout},      32'd0);
            chk("rst_ovf",       {31'd0, ovf},       32'd0);
        end else begin
            chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_rv});
            chk("cyc_in_ready",  {31'd0, in_ready},  {31'd0, (en && !m_busy && !m_rv)});
            if (m_rv) begin
                chk("cyc_sum",  {16'd0, sum},  {16'd0, m_sum});
                chk("cyc_cout", {31'd0, cout}, {31'd0, m_cout});
                chk("cyc_ovf",  {31'd0, ovf},  {31'd0, m_ovf});
            end
        end
    end

    task automatic send(input logic [W-1:0] v, input logic sel, input logic c);
        in_bus   = v;
        d_sel    = sel;
        cin      = c;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #2;
            lat++;
        end
    endtask

    task automatic result(input string name, input int exp_lat, input logic [W-1:0] es,
                          input logic ec, input logic eo, input int hold);
        int lat;
        wait_valid(lat);
        chk({name, "_lat"},  lat, exp_lat);
        chk({name, "_sum"},  {16'd0, sum},  {16'd0, es});
        chk({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({name, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #2;
            chk({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({name, "_hold_sum"},   {16'd0, sum},       {16'd0, es});
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        chk({name, "_released"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        en    = 1'b1;
        #1 chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Plain add
        send(16'h1234, 1'b0, 1'b0);
        send(16'h1111, 1'b1, 1'b0);
        result("t1_add", 4, 16'h2345, 1'b0, 1'b0, 0);

        // Carry through every slice, without and with cin
        send(16'hFFFF, 1'b0, 1'b0);
        send(16'h0001, 1'b1, 1'b0);
        result("t2_carry", 4, 16'h0000, 1'b1, 1'b0, 0);
        send(16'hFFFF, 1'b0, 1'b1);
        send(16'h0001, 1'b1, 1'b1);
        result("t2_cin", 4, 16'h0001, 1'b1, 1'b0, 0);

        // Signed overflow
        send(16'h7FFF, 1'b0, 1'b0);
        send(16'h0001, 1'b1, 1'b0);
        result("t3_ovf", 4, 16'h8000, 1'b0, 1'b1, 0);

        // Overwrite A, then complete with B while in_valid stays high through CALC/DONE
        send(16'h0005, 1'b0, 1'b0);
        send(16'h0007, 1'b0, 1'b0);
        in_bus   = 16'h0001;
        d_sel    = 1'b1;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_bus = 16'h0009;
        d_sel  = 1'b0;
        repeat (2) begin
            chk("t4_in_ready_calc", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #2;
        end
        wait_valid(lat);
        chk("t4_lat_rest", lat, 2);
        chk("t4_in_ready_done", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        result("t4_overwrite", 0, 16'h0008, 1'b0, 1'b0, 0);

        // Back-pressure: result held for 10 clocks
        send(16'h1234, 1'b0, 1'b0);
        send(16'h1111, 1'b1, 1'b0);
        result("t5_hold", 4, 16'h2345, 1'b0, 1'b0, 10);

        // Enable low for 3 clocks after the first slice
        send(16'h1234, 1'b0, 1'b0);
        send(16'h1111, 1'b1, 1'b0);
        @(posedge clk); #2;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        en = 1'b1;
        result("t5_en", 3, 16'h2345, 1'b0, 1'b0, 0);

        // Reset after two slices of a CALC
        send(16'h1234, 1'b0, 1'b0);
        send(16'h1111, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_sum",       {16'd0, sum},       32'd0);
        chk("t6_rst_in_ready",  {31'd0, in_ready},  32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1 chk("t6_post_in_ready", {31'd0, in_ready}, 32'd1);
        send(16'h0F0F, 1'b0, 1'b0);
        send(16'h00F1, 1'b1, 1'b0);
        result("t6_after", 4, 16'h1000, 1'b0, 1'b0, 0);

`ifdef SUB_MODE_EN
        // Subtraction with borrow
        sub_op = 1'b1;
        send(16'h0005, 1'b0, 1'b0);
        send(16'h0007, 1'b1, 1'b0);
        result("t7_sub", 4, 16'hFFFE, 1'b0, 1'b0, 0);
        sub_op = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
